// File: rtl/ili9341_init_seq_if.sv
// Init-sequencer bus: ROM fetch port plus the SPI byte-transmitter handshake.
interface ili9341_init_seq_if #(
    parameter int unsigned AW = 6
);
    logic [AW-1:0] rom_addr;
    logic [9:0]    rom_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_byte;
    logic          tx_dc;

    // Sequencer side: drives the ROM address and offers bytes.
    modport master (
        output rom_addr,
        input  rom_data,
        output tx_valid,
        input  tx_ready,
        output tx_byte,
        output tx_dc
    );

    // ROM / transmitter side.
    modport slave (
        input  rom_addr,
        output rom_data,
        input  tx_valid,
        output tx_ready,
        input  tx_byte,
        input  tx_dc
    );
endinterface

// File: rtl/ili9341_init_seq.sv
// ILI9341 power-up sequencer: panel reset pulse, then walks the init ROM issuing
// command/data bytes to the SPI transmitter, with ROM-encoded delays in between.
module ili9341_init_seq #(
    parameter int unsigned ROM_DEPTH         = 64,
    parameter int unsigned RESET_LOW_CYCLES  = 1000,
    parameter int unsigned RESET_WAIT_CYCLES = 5000,
    parameter int unsigned DELAY_UNIT        = 1000,
    localparam int unsigned AW               = $clog2(ROM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    ili9341_init_seq_if.master         bus,
    output logic                       lcd_rst_n,
    output logic                       busy,
    output logic                       done
);
    // Counter must hold the longest wait; the delay product is taken at 64 bits.
    localparam longint unsigned DLY_MAX = 64'(255) * 64'(DELAY_UNIT);
    localparam longint unsigned RST_MAX =
        (RESET_LOW_CYCLES > RESET_WAIT_CYCLES) ? 64'(RESET_LOW_CYCLES) : 64'(RESET_WAIT_CYCLES);
    localparam longint unsigned CNT_MAX = (DLY_MAX > RST_MAX) ? DLY_MAX : RST_MAX;
    localparam int unsigned     CW      = $clog2(CNT_MAX + 1);

    localparam logic [AW-1:0] LAST_ADDR = AW'(ROM_DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRstLow,
        StRstWait,
        StFetch,
        StDecode,
        StSend,
        StDelay,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    byte_q, byte_d;
    logic          dc_q, dc_d;
    logic          tx_valid_q;
    logic          lcd_rst_n_q;
    logic          busy_q;
    logic          done_q;

    logic          adv;
    logic [63:0]   dly_prod;

    // Next-state logic: sequencing, counter and ROM address control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        byte_d   = byte_q;
        dc_d     = dc_q;
        adv      = 1'b0;
        dly_prod = 64'(bus.rom_data[7:0]) * 64'(DELAY_UNIT);

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRstLow;
                    cnt_d   = CW'(RESET_LOW_CYCLES - 1);
                    addr_d  = '0;
                end
            end
            StRstLow: begin
                if (cnt_q == '0) begin
                    state_d = StRstWait;
                    cnt_d   = CW'(RESET_WAIT_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StRstWait: begin
                if (cnt_q == '0) begin
                    state_d = StFetch;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                unique case (bus.rom_data[9:8])
                    2'b00, 2'b01: begin
                        state_d = StSend;
                        byte_d  = bus.rom_data[7:0];
                        dc_d    = bus.rom_data[8];
                    end
                    2'b10: begin
                        if (bus.rom_data[7:0] != 8'd0) begin
                            state_d = StDelay;
                            cnt_d   = CW'(dly_prod - 64'd1);
                        end else begin
                            adv = 1'b1;
                        end
                    end
                    default: begin
                        state_d = StDone;
                    end
                endcase
            end
            StSend: begin
                if (bus.tx_ready) begin
                    adv = 1'b1;
                end
            end
            StDelay: begin
                if (cnt_q == '0) begin
                    adv = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Advance to the next entry; the address saturates at the last entry.
        if (adv) begin
            if (addr_q == LAST_ADDR) begin
                state_d = StDone;
            end else begin
                addr_d  = addr_q + AW'(1);
                state_d = StFetch;
            end
        end
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            byte_q      <= 8'd0;
            dc_q        <= 1'b0;
            tx_valid_q  <= 1'b0;
            lcd_rst_n_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            byte_q      <= byte_d;
            dc_q        <= dc_d;
            tx_valid_q  <= (state_d == StSend);
            lcd_rst_n_q <= (state_d != StRstLow);
            busy_q      <= (state_d != StIdle) && (state_d != StDone);
            done_q      <= (state_d == StDone);
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_byte  = byte_q;
    assign bus.tx_dc    = dc_q;
    assign lcd_rst_n    = lcd_rst_n_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_ili9341_init_seq.sv
// Directed bench for ili9341_init_seq with small timing parameters.
module tb_ili9341_init_seq;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic lcd_rst_n, busy, done;

    ili9341_init_seq_if #(.AW(4)) bus ();

    ili9341_init_seq #(
        .ROM_DEPTH        (16),
        .RESET_LOW_CYCLES (4),
        .RESET_WAIT_CYCLES(6),
        .DELAY_UNIT       (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .lcd_rst_n(lcd_rst_n),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [9:0] rom [0:DEPTH-1];
    int cyc = 0;
    int start_cyc = 0;
    int total = 0;
    int bad = 0;

    logic [7:0] hs_byte [0:127];
    logic       hs_dc   [0:127];
    int         hs_cyc  [0:127];
    int         hs_n = 0;

    // Synchronous ROM model: data valid one cycle after the address changes.
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake log, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.tx_valid && bus.tx_ready && hs_n < 128) begin
            hs_byte[hs_n] = bus.tx_byte;
            hs_dc[hs_n]   = bus.tx_dc;
            hs_cyc[hs_n]  = cyc;
            hs_n          = hs_n + 1;
        end
    end

    task automatic load_rom(input logic [9:0] e0, input logic [9:0] e1,
                            input logic [9:0] e2, input logic [9:0] e3);
        for (int i = 0; i < int'(DEPTH); i++) rom[i] = 10'h300;
        rom[0] = e0;
        rom[1] = e1;
        rom[2] = e2;
        rom[3] = e3;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({lcd_rst_n, bus.tx_valid, bus.tx_byte, bus.tx_dc, bus.rom_addr, busy, done}
            !== {1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: got rst_n=%b v=%b byte=%h dc=%b addr=%0d busy=%b done=%b",
                     lcd_rst_n, bus.tx_valid, bus.tx_byte, bus.tx_dc, bus.rom_addr, busy, done);
        end
    endtask

    // ROM {END}: low k=1..4, RST_WAIT k=5..10, FETCH 11, DECODE 12, done at 13.
    task automatic test_reset_pulse();
        int low_n = 0;
        int first_high = 0;
        int done_k = 0;
        bit busy_ok = 1'b1;
        bit addr_ok = 1'b1;
        load_rom(10'h300, 10'h300, 10'h300, 10'h300);
        pulse_start();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!lcd_rst_n) low_n++;
            if (lcd_rst_n && first_high == 0) first_high = k;
            if (k <= 12 && busy !== 1'b1) busy_ok = 1'b0;
            if (bus.rom_addr !== 4'd0) addr_ok = 1'b0;
            if (done && done_k == 0) done_k = k;
        end
        total++;
        if (low_n != 4 || first_high != 5) begin
            bad++;
            $display("FAIL rst_low_len: got low=%0d first_high=%0d, want 4 and 5", low_n, first_high);
        end
        total++;
        if (done_k != 13) begin
            bad++;
            $display("FAIL end_timing: done at k=%0d, want 13", done_k);
        end
        total++;
        if (!busy_ok || !addr_ok) begin
            bad++;
            $display("FAIL pulse_busy_addr: busy_ok=%b addr_ok=%b, want 1 1", busy_ok, addr_ok);
        end
    endtask

    task automatic test_basic();
        int base;
        bit ok;
        bus.tx_ready = 1'b1;
        load_rom(10'h001, 10'h1AB, 10'h300, 10'h300);
        base = hs_n;
        pulse_start();
        wait_done(100, ok);
        total++;
        if (!ok || hs_n - base != 2) begin
            bad++;
            $display("FAIL basic_count: done=%b handshakes=%0d, want 1 and 2", ok, hs_n - base);
        end else begin
            total++;
            if ({hs_byte[base], hs_dc[base], hs_byte[base+1], hs_dc[base+1]}
                !== {8'h01, 1'b0, 8'hAB, 1'b1}) begin
                bad++;
                $display("FAIL basic_bytes: got %h/%b %h/%b, want 01/0 ab/1",
                         hs_byte[base], hs_dc[base], hs_byte[base+1], hs_dc[base+1]);
            end
            total++;
            if (hs_cyc[base] - start_cyc + 1 != 13 || hs_cyc[base+1] - hs_cyc[base] != 3) begin
                bad++;
                $display("FAIL basic_timing: first k=%0d spacing=%0d, want 13 and 3",
                         hs_cyc[base] - start_cyc + 1, hs_cyc[base+1] - hs_cyc[base]);
            end
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: done=%b busy=%b, want 1 0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        int base;
        bit ok;
        bit seen = 1'b0;
        bit stable = 1'b1;
        bus.tx_ready = 1'b0;
        load_rom(10'h001, 10'h1AB, 10'h300, 10'h300);
        base = hs_n;
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.tx_valid) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL bp_valid_rise: tx_valid=0 after 40 cycles, want 1");
        end
        for (int i = 0; i < 10; i++) begin
            if ({bus.tx_valid, bus.tx_byte, bus.tx_dc} !== {1'b1, 8'h01, 1'b0}) stable = 1'b0;
            @(negedge clk);
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL bp_stable: v/byte/dc changed while stalled, want 1/01/0 held");
        end
        @(posedge clk);
        #1 bus.tx_ready = 1'b1;
        wait_done(100, ok);
        repeat (3) @(negedge clk);
        total++;
        if (!ok || hs_n - base != 2) begin
            bad++;
            $display("FAIL bp_count: done=%b handshakes=%0d, want 1 and 2", ok, hs_n - base);
        end else if (hs_byte[base] !== 8'h01 || hs_byte[base+1] !== 8'hAB) begin
            bad++;
            $display("FAIL bp_count: bytes %h %h, want 01 ab", hs_byte[base], hs_byte[base+1]);
        end
    endtask

    // Spacing = SEND(1) + FETCH + DECODE + value*3 + FETCH + DECODE.
    task automatic test_delays();
        int base;
        bit ok;
        bus.tx_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            int want;
            want = (pass == 0) ? 20 : 5;
            if (pass == 0) load_rom(10'h011, 10'h205, 10'h029, 10'h300);
            else load_rom(10'h011, 10'h200, 10'h029, 10'h300);
            base = hs_n;
            pulse_start();
            wait_done(200, ok);
            total++;
            if (!ok || hs_n - base != 2) begin
                bad++;
                $display("FAIL delay_count%0d: done=%b handshakes=%0d, want 1 and 2",
                         pass, ok, hs_n - base);
            end else if (hs_cyc[base+1] - hs_cyc[base] != want || hs_byte[base+1] !== 8'h29) begin
                bad++;
                $display("FAIL delay_spacing%0d: spacing=%0d byte=%h, want %0d and 29",
                         pass, hs_cyc[base+1] - hs_cyc[base], hs_byte[base+1], want);
            end
        end
    endtask

    task automatic test_no_end();
        int base;
        bit ok = 1'b0;
        bit mono = 1'b1;
        bit data_ok = 1'b1;
        logic [3:0] prev = 4'd0;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [7:0] v;
            v = 8'h40 + 8'(i);
            rom[i] = {1'b0, v[0], v};
        end
        base = hs_n;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.rom_addr < prev) mono = 1'b0;
            prev = bus.rom_addr;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (5) @(negedge clk);
        total++;
        if (!ok || hs_n - base != 16) begin
            bad++;
            $display("FAIL noend_count: done=%b handshakes=%0d, want 1 and 16", ok, hs_n - base);
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (hs_byte[base+i] !== 8'h40 + 8'(i) || hs_dc[base+i] !== 1'(i % 2)) data_ok = 1'b0;
            end
            total++;
            if (!data_ok) begin
                bad++;
                $display("FAIL noend_data: byte/dc sequence wrong, want 40..4f with alternating dc");
            end
        end
        total++;
        if (bus.rom_addr !== 4'd15 || !mono || done !== 1'b1) begin
            bad++;
            $display("FAIL noend_addr: addr=%0d monotonic=%b done=%b, want 15 1 1",
                     bus.rom_addr, mono, done);
        end
    endtask

    task automatic test_interrupt();
        int base;
        bit seen = 1'b0;
        bit held = 1'b1;
        bit quiet = 1'b1;
        bus.tx_ready = 1'b0;
        load_rom(10'h011, 10'h205, 10'h029, 10'h300);
        base = hs_n;
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.tx_valid) begin
                seen = 1'b1;
                break;
            end
        end
        // start while busy must not restart the reset pulse.
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (!lcd_rst_n || !bus.tx_valid || bus.tx_byte !== 8'h11 || !busy) held = 1'b0;
        end
        total++;
        if (!seen || !held) begin
            bad++;
            $display("FAIL start_ignored: seen=%b held=%b, want 1 1", seen, held);
        end
        @(posedge clk);
        #1 bus.tx_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.tx_valid !== 1'b0 || busy !== 1'b1 || hs_n - base != 1) begin
            bad++;
            $display("FAIL in_delay: v=%b busy=%b hs=%0d, want 0 1 1", bus.tx_valid, busy, hs_n - base);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({lcd_rst_n, bus.tx_valid, bus.tx_byte, bus.tx_dc, bus.rom_addr, busy, done}
            !== {1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rst_mid_delay: got rst_n=%b v=%b byte=%h dc=%b addr=%0d busy=%b done=%b",
                     lcd_rst_n, bus.tx_valid, bus.tx_byte, bus.tx_dc, bus.rom_addr, busy, done);
        end
        repeat (20) begin
            @(negedge clk);
            if (bus.tx_valid || busy || done) quiet = 1'b0;
        end
        total++;
        if (!quiet || hs_n - base != 1) begin
            bad++;
            $display("FAIL idle_after_rst: quiet=%b hs=%0d, want 1 1", quiet, hs_n - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        bus.tx_ready = 1'b1;
        load_rom(10'h001, 10'h1AB, 10'h300, 10'h300);
        pulse_start();
        wait_done(100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_first_done: done=0 after 100 cycles, want 1");
        end
        base = hs_n;
        pulse_start();
        @(negedge clk);
        total++;
        if ({done, busy, lcd_rst_n, bus.rom_addr} !== {1'b0, 1'b1, 1'b0, 4'h0}) begin
            bad++;
            $display("FAIL b2b_restart: done=%b busy=%b rst_n=%b addr=%0d, want 0 1 0 0",
                     done, busy, lcd_rst_n, bus.rom_addr);
        end
        wait_done(100, ok);
        total++;
        if (!ok || hs_n - base != 2 || hs_cyc[base] - start_cyc + 1 != 13) begin
            bad++;
            $display("FAIL b2b_rerun: done=%b hs=%0d first k=%0d, want 1 2 13",
                     ok, hs_n - base, hs_cyc[base] - start_cyc + 1);
        end
    endtask

    initial begin
        bus.tx_ready = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) rom[i] = 10'h300;
        test_reset();
        test_reset_pulse();
        test_basic();
        test_backpressure();
        test_delays();
        test_no_end();
        test_interrupt();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ili9341_init_seq.md
# ili9341_init_seq

Power-up sequencer for the ILI9341 display path. On `start` it pulses the panel hardware reset, then walks an external init ROM and issues each command or data byte to the SPI byte transmitter through a valid/ready handshake. ROM-encoded delays are inserted between bytes. It is the single owner of the SPI transmitter until `done` asserts.

## Interface
- `ROM_DEPTH`, 64: number of ROM entries; `AW = $clog2(ROM_DEPTH)`.
- `RESET_LOW_CYCLES`, 1000: `lcd_rst_n` low time, in clk cycles.
- `RESET_WAIT_CYCLES`, 5000: wait after reset release before the first ROM fetch.
- `DELAY_UNIT`, 1000: clk cycles per unit of a ROM delay entry.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin sequence; sampled only in IDLE and DONE.
- `rom_addr` out AW: registered ROM address.
- `rom_data` in 10: `[9:8]` type, `[7:0]` value; valid 1 cycle after `rom_addr` changes.
- `tx_valid` out 1: byte offered to the SPI transmitter.
- `tx_ready` in 1: transmitter accepts the byte when `tx_valid && tx_ready`.
- `tx_byte` out 8: byte to send.
- `tx_dc` out 1: 0 = command, 1 = data.
- `lcd_rst_n` out 1: panel hardware reset, active-low.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high in DONE only.

## Operation
- ROM entry types:
  - 00: CMD. Send value with `tx_dc=0`.
  - 01: DATA. Send value with `tx_dc=1`.
  - 10: DELAY. Wait value×DELAY_UNIT cycles; value 0 means no wait.
  - 11: END. Sequence complete.
- FSM states: IDLE, RST_LOW, RST_WAIT, FETCH, DECODE, SEND, DELAY, DONE.
- IDLE/DONE to RST_LOW when `start`=1. Entering RST_LOW clears `rom_addr` to 0 and `done` to 0.
- RST_LOW: `lcd_rst_n`=0 for exactly RESET_LOW_CYCLES cycles, then go to RST_WAIT.
- RST_WAIT: `lcd_rst_n`=1 for RESET_WAIT_CYCLES cycles, then go to FETCH.
- FETCH: lasts one cycle; `rom_addr` is stable. Then go to DECODE.
- DECODE: registers `rom_data`, then branches:
  - CMD/DATA: go to SEND.
  - DELAY with value>0: go to DELAY.
  - DELAY with value 0: go to advance.
  - END: go to DONE.
- SEND: `tx_valid`=1 with `tx_byte`/`tx_dc` held constant until handshake. On the handshake cycle, drop `tx_valid` on the next edge and go to advance.
- DELAY: down-counter of value×DELAY_UNIT cycles, then go to advance.
- Advance:
  - If `rom_addr`==ROM_DEPTH-1, go to DONE; the address never wraps.
  - Otherwise `rom_addr`+1, go to FETCH.
- `start` while `busy` is ignored. `start` in DONE reruns the full sequence, including the reset pulse.
- One shared cycle counter, sized for max(RESET_LOW_CYCLES, RESET_WAIT_CYCLES, 255×DELAY_UNIT). The product is computed at full width with no truncation.
- `tx_ready` outside SEND has no effect.

## Timing
- Reset values: state IDLE, `lcd_rst_n`=1, `tx_valid`=0, `tx_byte`=0, `tx_dc`=0, `rom_addr`=0, `busy`=0, `done`=0, counter=0.
- `rst` has priority over everything. If asserted mid-sequence, all outputs take their reset values at the next edge and any pending byte is abandoned.
- `start` sampled at edge N gives RST_LOW from N+1; `lcd_rst_n` is low during cycles N+1 … N+RESET_LOW_CYCLES.
- Cycle sequence after the reset pulse:
  - RST_WAIT lasts RESET_WAIT_CYCLES cycles.
  - FETCH lasts 1 cycle.
  - DECODE lasts 1 cycle.
  - `tx_valid` rises in the following cycle.
- Per-byte overhead with `tx_ready` held at 1: 3 cycles per CMD/DATA entry (FETCH, DECODE, SEND).
- DELAY entry cost: 2 + value×DELAY_UNIT cycles.
- END entry: `done`=1 and `busy`=0 two cycles after its FETCH, held until `start` or `rst`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Parameters for all scenarios: RESET_LOW_CYCLES=4, RESET_WAIT_CYCLES=6, DELAY_UNIT=3, ROM_DEPTH=16.

- **Reset pulse.** Pulse `start` for 1 cycle → `lcd_rst_n` low exactly 4 cycles, then high; `rom_addr`=0 FETCH 6 cycles later; `busy`=1 throughout.
- **Basic command/data.** ROM = {CMD 0x01, DATA 0xAB, END}, `tx_ready`=1 → handshakes (0x01, dc0) then (0xAB, dc1), spaced 3 cycles apart; `done`=1, `busy`=0.
- **Backpressure.** `tx_ready`=0 for 10 cycles on the first byte → `tx_valid`, `tx_byte`, `tx_dc` stable the whole time; exactly one handshake per entry.
- **Delays.** ROM = {CMD 0x11, DELAY 5, CMD 0x29, END} → 15 idle cycles plus 2 overhead between handshakes; a DELAY 0 entry adds only 2 cycles.
- **Missing END.** ROM with no END entry → sends all 16 entries, then DONE; `rom_addr` stops at 15 and never returns to 0.
- **Interruptions.** `start` pulsed mid-SEND → ignored. `rst` asserted mid-DELAY → next cycle all reset values, IDLE. Afterwards, `start` in DONE → new reset pulse and `done` drops.
